// File: rtl/rx_deserializer.sv
// Receive-side deserializer: captures mid-bit samples into an LSB-first character,
// checks start/stop framing, and queues {frame_err, data} in a small show-ahead FIFO.
module rx_deserializer #(
    parameter int           DEPTH = 4,
    parameter logic [3:0]   MID   = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       serial_in,
    input  logic [3:0] sample,
    input  logic [3:0] bit_idx,
    input  logic       char_rs,
    input  logic       pop,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       empty,
    output logic       full,
    output logic       overrun
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       shreg_q, shreg_d;
    logic             start_bad_q, start_bad_d;
    logic             stop_bad_q, stop_bad_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [8:0]       mem_q [DEPTH];

    logic       capture;
    logic       do_push;
    logic       do_pop;
    logic       drop;
    logic [8:0] head;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign capture = enable && (sample == MID);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a character when the head leaves on the same edge.
    assign do_push = char_rs && (!full || do_pop);
    assign drop    = char_rs && full && !do_pop;

    always_comb begin
        shreg_d     = shreg_q;
        start_bad_d = start_bad_q;
        stop_bad_d  = stop_bad_q;
        if (capture) begin
            if (bit_idx == 4'd0)
                start_bad_d = serial_in;
            if (bit_idx == 4'd9)
                stop_bad_d = ~serial_in;
            for (int i = 0; i < 8; i++) begin
                if (bit_idx == 4'(i + 1))
                    shreg_d[i] = serial_in;
            end
        end
        // The frame is finished once char_rs arrives, even if its character is dropped.
        if (char_rs) begin
            shreg_d     = '0;
            start_bad_d = 1'b0;
            stop_bad_d  = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (do_push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CNT_W'(1);
        if (clr_err)
            overrun_d = 1'b0;
        if (drop)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_q     <= '0;
            start_bad_q <= 1'b0;
            stop_bad_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            start_bad_q <= start_bad_d;
            stop_bad_q  <= stop_bad_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push)
            mem_q[wr_ptr_q] <= {start_bad_q | stop_bad_q, shreg_q};
    end

    // Storage is not reset; outputs are masked while the FIFO is empty.
    assign head      = mem_q[rd_ptr_q];
    assign data      = empty ? 8'h00 : head[7:0];
    assign frame_err = empty ? 1'b0  : head[8];
    assign overrun   = overrun_q;
endmodule

// File: doc/rx_deserializer.md
# rx_deserializer

Receive-side deserializer for the serial link, directly downstream of the bit index counter. It captures the mid-bit sample of each bit position, assembles an 8-bit character LSB-first, and checks the start and stop bits. When the counter's character-received pulse arrives, it pushes the character and its framing status into a small show-ahead FIFO. The consumer (character decode / game logic) drains the FIFO with a pop strobe.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- MID, 4'b0111, sample-count value at which a bit is captured (16x oversampling)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low: registers clear on a rising clk edge where rst==0
- enable  input  1  receiver active; no capture when 0
- serial_in  input  1  synchronized serial line (idle high)
- sample  input  4  oversample count from upstream sample counter
- bit_idx  input  4  current bit index from bit index counter (0 start, 1–8 data, 9 stop)
- char_rs  input  1  one-cycle pulse: character complete
- pop  input  1  consumer removes head entry
- clr_err  input  1  clears sticky overrun flag
- data  output  8  head-of-FIFO character (valid when empty==0)
- frame_err  output  1  head entry's framing error bit
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- overrun  output  1  sticky: a character was dropped

## Operation
- Capture: on a clk edge with enable==1 and sample==MID:
  - bit_idx 0: start_bad <= serial_in (a 1 means bad start).
  - bit_idx 1–8: shreg[bit_idx-1] <= serial_in, so bit 1 is the LSB.
  - bit_idx 9: stop_bad <= ~serial_in.
  - bit_idx ≥10: ignored.
- Push: on char_rs==1, entry {start_bad|stop_bad, shreg} is written at the write pointer, and the write pointer increments modulo DEPTH. char_rs is honoured regardless of enable.
- After a push, shreg, start_bad and stop_bad clear to 0 on the same edge, ready for the next frame.
- Pop: on pop==1 and empty==0, the read pointer increments modulo DEPTH. pop while empty is ignored with no state change.
- Count register, width log2(DEPTH)+1:
  - push only: +1
  - pop only: −1
  - both: unchanged
- empty = (count==0); full = (count==DEPTH).
- Full with push and no pop: the character is dropped, pointers are unchanged, and overrun <= 1.
- Full with push and pop in the same cycle: both occur and no overrun.
- overrun stays set until clr_err==1 or reset. If clr_err and a new overrun coincide, the set wins (overrun stays 1).
- data and frame_err are read combinationally from the entry at the read pointer (show-ahead).
- Reset (rst==0):
  - pointers, count, shreg, start_bad, stop_bad and overrun all go to 0.
  - Outputs after reset: empty=1, full=0, overrun=0, frame_err=0, data=8'h00. Storage is cleared or masked so data reads 0 while empty.
  - A reset mid-frame discards the partial character; char_rs during reset is ignored.

## Timing
- Bit capture: serial_in is registered on the edge where sample==MID; there is no extra pipeline.
- Push latency: data, frame_err and empty==0 are valid in the cycle after the edge on which char_rs==1.
- Pop: the next entry appears in the cycle after the pop edge; back-to-back pops every cycle are allowed.
- full and empty are registered-count derived and update on the same edge as the push or pop.
- Throughput: one character per char_rs pulse; the minimum pulse spacing is 1 cycle.

## Test plan
- Frame 0xA5 (line: start 0, bits 1,0,1,0,0,1,0,1, stop 1) at MID sampling, then char_rs -> next cycle: empty=0, data=8'hA5, frame_err=0.
- Same frame with stop bit 0 -> data=8'hA5, frame_err=1. Frame with start sampled 1 -> frame_err=1.
- Push 5 characters 0x01–0x05 with DEPTH=4 and no pops -> full=1 after the 4th push, overrun=1 after the 5th. Pops return 0x01–0x04, then empty=1. clr_err -> overrun=0.
- FIFO full, char_rs and pop on the same edge (new char 0x55) -> overrun stays 0, count stays 4, and 0x55 is read last.
- rst=0 asserted after bit_idx 4 of a frame, then released, then a full frame 0x3C -> empty=1 during reset, and the first entry read is 0x3C with no residue from the partial frame.
- pop while empty and sample≠MID toggling of serial_in -> no change to data, empty, or shreg contents of the next frame.
